mult_seq_ctrl: RTL and testbench

- Sequencing controller placed directly upstream of the shift-add accumulator stage in the multiplier datapath.
- Accepts one operand pair (multiplicand A, multiplier B) per start request.
- Holds A stable, clears the accumulator, then walks the bit index 0..N-1, asserting enable exactly when the current B bit is 1.
- Signals done once the accumulator holds the final product A*B.

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_seq_ctrl.sv | 100 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding and
// the default operand/count widths also used by the accumulator stage.
package mult_pkg;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for a shift-add accumulator: captures A/B, clears the accumulator,
// then walks bit indices issuing add-enables. Optional MULT_EARLY_TERM_EN stops once B is exhausted.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic [N-1:0]     a_out,
  output logic [CNT_W-1:0] count,
  output logic             enable,
  output logic             acc_clr,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_e           state_q;
  logic [N-1:0]     a_out_q;
  logic [N-1:0]     b_sh_q;
  logic [CNT_W-1:0] count_q;
  logic             enable_q;
  logic             acc_clr_q;
  logic             busy_q;
  logic             done_q;
  logic             run_last;

`ifdef MULT_EARLY_TERM_EN
  // No set bits remain above the current one, so further RUN cycles would add nothing.
  assign run_last = (b_sh_q[N-1:1] == '0) || (count_q == LAST_IDX);
`else
  assign run_last = (count_q == LAST_IDX);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_out_q   <= '0;
      b_sh_q    <= '0;
      count_q   <= '0;
      enable_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_out_q   <= a_in;
            b_sh_q    <= b_in;
            count_q   <= '0;
            enable_q  <= 1'b0;
            acc_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          acc_clr_q <= 1'b0;
          enable_q  <= b_sh_q[0];
          count_q   <= '0;
          state_q   <= RUN;
        end
        RUN: begin
          b_sh_q <= b_sh_q >> 1;
          if (run_last) begin
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            // Outputs are registered, so the next index looks one bit ahead.
            enable_q <= b_sh_q[1];
            count_q  <= count_q + CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_out   = a_out_q;
  assign count   = count_q;
  assign enable  = enable_q;
  assign acc_clr = acc_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural shift-add accumulator downstream;
// expectations are hand-computed for both the default and MULT_EARLY_TERM_EN builds.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  localparam int N  = 8;
  localparam int CW = 3;
`ifdef MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  a_in;
  logic [N-1:0]  b_in;
  logic [N-1:0]  a_out;
  logic [CW-1:0] count;
  logic          enable;
  logic          acc_clr;
  logic          busy;
  logic          done;
  logic [2*N-1:0] acc_q;

  int errors = 0;
  int checks = 0;

  mult_seq_ctrl #(.N(N), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .a_out  (a_out),
    .count  (count),
    .enable (enable),
    .acc_clr(acc_clr),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream accumulator: clear on acc_clr or reset, else add a_out << count when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         acc_q <= '0;
    else if (acc_clr) acc_q <= '0;
    else if (enable)  acc_q <= acc_q + ({{N{1'b0}}, a_out} << count);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a_out"},   32'(a_out),   32'd0);
    check({tag, ".count"},   32'(count),   32'd0);
    check({tag, ".enable"},  32'(enable),  32'd0);
    check({tag, ".acc_clr"}, 32'(acc_clr), 32'd0);
    check({tag, ".busy"},    32'(busy),    32'd0);
    check({tag, ".done"},    32'(done),    32'd0);
  endtask

  // Starts one product at edge k and follows it to done; returns while in the DONE cycle.
  // inj_c > 0 drives a spurious start sampled at edge k+inj_c.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int exp_mask, input int exp_lat, input int exp_cnt,
                        input int exp_q, input int inj_c);
    int c;
    int mask;
    bit overlap;
    bit busy_bad;
    bit got_done;
    mask = 0; overlap = 1'b0; busy_bad = 1'b0; got_done = 1'b0;
    a_in = a; b_in = b; start = 1'b1;
    step();
    start = 1'b0; a_in = ~a; b_in = ~b;
    c = 1;
    check({tag, ".clr"}, 32'(acc_clr), 32'd1);
    while (!got_done && c <= 30) begin
      if (enable && acc_clr) overlap = 1'b1;
      if (enable) mask = mask | (32'd1 << count);
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (!busy) busy_bad = 1'b1;
        if (c == inj_c) begin
          start = 1'b1; a_in = 8'h5A; b_in = 8'hA5;
        end else begin
          start = 1'b0;
        end
        step();
        c++;
      end
    end
    start = 1'b0;
    check({tag, ".latency"},  got_done ? 32'(c) : 32'd0, 32'(exp_lat));
    check({tag, ".en_mask"},  32'(mask),     32'(exp_mask));
    check({tag, ".cnt_done"}, 32'(count),    32'(exp_cnt));
    check({tag, ".product"},  32'(acc_q),    32'(exp_q));
    check({tag, ".a_out"},    32'(a_out),    32'(a));
    check({tag, ".busy_done"},32'(busy),     32'd0);
    check({tag, ".overlap"},  32'(overlap),  32'd0);
    check({tag, ".busy_run"}, 32'(busy_bad), 32'd0);
    $display("op %s: A=%0d B=%0d Q=%0d done at k+%0d mask=%02h", tag, a, b, acc_q, c, mask);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    #12;
    check_all_zero("reset");
    #3 rst = 1'b1;
    step();
    step();

    run_op("13x11", 8'd13, 8'd11, 32'h0B, ET ? 6 : 10, ET ? 3 : 7, 143, 0);
    step();
    check("done_pulse", 32'(done), 32'd0);

    run_op("255x255", 8'd255, 8'd255, 32'hFF, 10, 7, 65025, 0);
    step();
    run_op("200x0", 8'd200, 8'd0, 32'h00, ET ? 3 : 10, ET ? 0 : 7, 0, 0);
    step();

    run_op("13x11_inj", 8'd13, 8'd11, 32'h0B, ET ? 6 : 10, ET ? 3 : 7, 143, 4);
    step();
    run_op("7x2_b2b", 8'd7, 8'd2, 32'h02, ET ? 4 : 10, ET ? 1 : 7, 14, 0);
    step();

    // Abort a product in cycle k+5 with an asynchronous reset.
    a_in = 8'd100; b_in = 8'h80; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    check("abort.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("abort");
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    check("abort.no_done", 32'(seen_done), 32'd0);
    check("abort.acc", 32'(acc_q), 32'd0);
    #3 rst = 1'b1;
    step();
    run_op("9x6_post_rst", 8'd9, 8'd6, 32'h06, ET ? 5 : 10, ET ? 2 : 7, 54, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
